dram_wbl_wr_ctrl: RTL and testbench
===================================

# dram_wbl_wr_ctrl

Write-side responder for the DRAM key/S-box programming interface. It accepts a one-cycle `IO_EN` write request carrying a 6-bit row address and sixteen 64-bit write-bitline words. It then sequences the array write phases (precharge, bitline setup, wordline pulse, recovery) and returns a one-cycle `wr_done`. It sits between the key/S-box initialiser and the CIM DRAM macro, and is the only block that drives the macro's write controls.

## Interface
- `T_PRE`, default 2: precharge phase length in cycles (≥1).
- `T_SETUP`, default 1: bitline setup phase length in cycles before wordline (≥1).
- `T_WL`, default 4: wordline-high phase length in cycles (≥1).
- `T_REC`, default 2: recovery phase length in cycles after wordline drop (≥1).
- `CLK`  in  1  single clock; all logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `IO_EN`  in  1  write request; each high cycle is one request.
- `ADDR`  in  6  row address; sampled with `IO_EN`.
- `WBL_DATA1`..`WBL_DATA16`  in  64 each  write words; sampled with `IO_EN`.
- `wr_done`  out  1  one-cycle write-complete pulse.
- `BUSY`  out  1  high from acceptance until `wr_done`.
- `PRE`  out  1  bitline precharge enable.
- `WBL_EN`  out  1  write-bitline driver enable.
- `WBL_OUT`  out  1024  latched data, {`WBL_DATA16`, …, `WBL_DATA1`}; `WBL_DATA1` occupies [63:0].
- `WL_EN`  out  1  wordline enable.
- `WL_SEL`  out  64  one-hot row select, bit `ADDR`. Non-zero only while `WL_EN` is high.
- `ERR`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE → PRE → SETUP → WL → REC → IDLE.
- IDLE with `IO_EN`=1 at an edge:
  - Latch `ADDR` and all 16 words.
  - Set `BUSY`.
  - Enter PRE.
- Phase outputs:
  - PRE: `PRE`=1.
  - SETUP: `WBL_EN`=1.
  - WL: `WBL_EN`=1, `WL_EN`=1, `WL_SEL`=onehot(addr).
  - REC: all array controls 0.
- Each phase holds for its parameter's cycle count, using a down-counter loaded on phase entry.
- Leaving REC:
  - Clear `BUSY`.
  - Assert `wr_done` for exactly the first IDLE cycle.
- `IO_EN` in the cycle where `wr_done`=1 is accepted normally. This gives back-to-back writes with no dead cycle.
- `IO_EN` while `BUSY`=1 is ignored. Latched data and address are unchanged. No extra `wr_done` is produced.
- `WBL_OUT` holds the last latched data between writes. `WBL_EN` gates its effect on the array.
- Address wrap: not applicable; all 64 rows are valid. Row 63 is handled like any other row.
- Reset:
  - All outputs read 0 after the reset edge: `WBL_OUT`, `WL_SEL`, `ERR`, `BUSY`, `wr_done`, `PRE`, `WBL_EN`, `WL_EN`.
  - State returns to IDLE.
- Reset mid-write abandons the write; no `wr_done` is issued.
- `RST` and `IO_EN` in the same cycle: reset wins and the request is dropped.

## Timing
- Request sampled at edge k. Array-control windows, in cycles after k:
  - `PRE` high: k+1 .. k+T_PRE.
  - `WBL_EN` high: k+T_PRE+1 .. k+T_PRE+T_SETUP+T_WL.
  - `WL_EN` high: the last T_WL cycles of the `WBL_EN` window.
- `wr_done` cycle: k + 1 + T_PRE + T_SETUP + T_WL + T_REC. With defaults this is k+10.
- `BUSY` high: k+1 through the cycle before `wr_done`.
- All outputs are registered; there are no combinational input-to-output paths.
- Bitlines are stable for ≥ T_SETUP cycles before `WL_EN` rises. Bitlines remain driven for the full `WL_EN` window.

## Configuration
- Macro: `DRAM_WR_ERR_CHECK_EN`.
- Defined:
  - `ERR` sets on `IO_EN`=1 while `BUSY`=1.
  - `ERR` also sets on `IO_EN`=1 held for two consecutive cycles in IDLE; the second cycle is still treated as a new request.
  - `ERR` clears only on `RST`.
- Undefined:
  - `ERR` is tied to 0 and no detection logic is built.
  - All other behaviour is identical.

## Structure
- Package `dram_wr_pkg` holds:
  - The state enum (IDLE, PRE, SETUP, WL, REC).
  - Constants `DRAM_ADDR_W`=6, `DRAM_WORD_W`=64, `DRAM_NUM_WBL`=16, `DRAM_ROWS`=64.
  - Default timing constants.
- Sub-module `dram_phase_timer`: loadable down-counter with `load`, `len`, and a `zero` flag, reused for every phase.
- The top level contains the FSM, data/address latches and the one-hot decode.

## Test plan
- Single write:
  - Stimulus: `ADDR`=0x05, `WBL_DATA1`=0x0123456789ABCDEF, other words 0, defaults.
  - Required: `WL_SEL`=0x20 during the 4 `WL_EN` cycles; `WBL_OUT[63:0]` holds the pattern; `wr_done` at k+10.
- Back-to-back, 64 rows:
  - Stimulus: `IO_EN` re-issued in each `wr_done` cycle, `ADDR` 0..63.
  - Required: 64 `wr_done` pulses spaced exactly 10 cycles apart; row 63 gives `WL_SEL`=0x8000_0000_0000_0000.
- Busy collision:
  - Stimulus: `IO_EN` with `ADDR`=0x10 at k+4 during a write to 0x02.
  - Required: latched row stays 0x02; a single `wr_done`; `ERR`=1 only with `DRAM_WR_ERR_CHECK_EN`.
- Reset mid-write:
  - Stimulus: `RST` asserted at k+6, during WL.
  - Required: next cycle all outputs are 0; no `wr_done`; a fresh `IO_EN` after reset completes normally.
- Parameter sweep:
  - Stimulus: T_PRE=1, T_SETUP=3, T_WL=1, T_REC=1.
  - Required: `wr_done` at k+7; `WL_EN` high exactly one cycle at k+5.

Source files
------------

// File: rtl/dram_wr_pkg.sv
// rtl/dram_wr_pkg.sv - shared types, sizes and timing defaults for the DRAM write controller
package dram_wr_pkg;

    localparam int DRAM_ADDR_W  = 6;
    localparam int DRAM_WORD_W  = 64;
    localparam int DRAM_NUM_WBL = 16;
    localparam int DRAM_ROWS    = 64;

    localparam int DRAM_T_PRE_DEF   = 2;
    localparam int DRAM_T_SETUP_DEF = 1;
    localparam int DRAM_T_WL_DEF    = 4;
    localparam int DRAM_T_REC_DEF   = 2;

    localparam int DRAM_TMR_W = 8;

    typedef enum logic [2:0] {
        WR_IDLE  = 3'd0,
        WR_PRE   = 3'd1,
        WR_SETUP = 3'd2,
        WR_WL    = 3'd3,
        WR_REC   = 3'd4
    } dram_wr_state_e;

    function automatic logic [DRAM_ROWS-1:0] row_onehot(input logic [DRAM_ADDR_W-1:0] a);
        logic [DRAM_ROWS-1:0] r;
        r    = '0;
        r[a] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/dram_phase_timer.sv
// rtl/dram_phase_timer.sv - loadable down-counter; a load of len gives exactly len cycles before zero
module dram_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = len - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dram_wbl_wr_ctrl.sv
// rtl/dram_wbl_wr_ctrl.sv - DRAM row write sequencer (PRE/SETUP/WL/REC); ERR detection built with DRAM_WR_ERR_CHECK_EN
module dram_wbl_wr_ctrl
    import dram_wr_pkg::*;
#(
    parameter int T_PRE   = DRAM_T_PRE_DEF,
    parameter int T_SETUP = DRAM_T_SETUP_DEF,
    parameter int T_WL    = DRAM_T_WL_DEF,
    parameter int T_REC   = DRAM_T_REC_DEF
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic                                IO_EN,
    input  logic [DRAM_ADDR_W-1:0]              ADDR,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA1,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA2,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA3,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA4,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA5,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA6,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA7,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA8,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA9,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA10,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA11,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA12,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA13,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA14,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA15,
    input  logic [DRAM_WORD_W-1:0]              WBL_DATA16,
    output logic                                wr_done,
    output logic                                BUSY,
    output logic                                PRE,
    output logic                                WBL_EN,
    output logic [DRAM_NUM_WBL*DRAM_WORD_W-1:0] WBL_OUT,
    output logic                                WL_EN,
    output logic [DRAM_ROWS-1:0]                WL_SEL,
    output logic                                ERR
);

    localparam int TMR_W = DRAM_TMR_W;

    localparam logic [2:0] S_IDLE  = WR_IDLE;
    localparam logic [2:0] S_PRE   = WR_PRE;
    localparam logic [2:0] S_SETUP = WR_SETUP;
    localparam logic [2:0] S_WL    = WR_WL;
    localparam logic [2:0] S_REC   = WR_REC;

    logic [2:0]                                state_q, state_d;
    logic                                      tmr_load, tmr_zero;
    logic [TMR_W-1:0]                          tmr_len;
    logic                                      accept;
    logic [DRAM_ADDR_W-1:0]                    addr_q, addr_d;
    logic [DRAM_NUM_WBL*DRAM_WORD_W-1:0]       wbl_q, wbl_d;
    logic                                      busy_q, busy_d;
    logic                                      done_q, done_d;
    logic                                      pre_q, pre_d;
    logic                                      wbl_en_q, wbl_en_d;
    logic                                      wl_en_q, wl_en_d;
    logic [DRAM_ROWS-1:0]                      wl_sel_q, wl_sel_d;

    dram_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk  (CLK),
        .rst  (RST),
        .load (tmr_load),
        .len  (tmr_len),
        .zero (tmr_zero)
    );

    // Each phase reloads the timer on the same edge that enters it.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_len  = '0;
        done_d   = 1'b0;
        accept   = (state_q == S_IDLE) && IO_EN;
        case (state_q)
            S_IDLE: begin
                if (IO_EN) begin
                    state_d  = S_PRE;
                    tmr_load = 1'b1;
                    tmr_len  = TMR_W'(T_PRE);
                end
            end
            S_PRE: begin
                if (tmr_zero) begin
                    state_d  = S_SETUP;
                    tmr_load = 1'b1;
                    tmr_len  = TMR_W'(T_SETUP);
                end
            end
            S_SETUP: begin
                if (tmr_zero) begin
                    state_d  = S_WL;
                    tmr_load = 1'b1;
                    tmr_len  = TMR_W'(T_WL);
                end
            end
            S_WL: begin
                if (tmr_zero) begin
                    state_d  = S_REC;
                    tmr_load = 1'b1;
                    tmr_len  = TMR_W'(T_REC);
                end
            end
            S_REC: begin
                if (tmr_zero) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the array sees glitch-free controls.
    always_comb begin
        addr_d   = accept ? ADDR : addr_q;
        wbl_d    = accept ? {WBL_DATA16, WBL_DATA15, WBL_DATA14, WBL_DATA13,
                             WBL_DATA12, WBL_DATA11, WBL_DATA10, WBL_DATA9,
                             WBL_DATA8,  WBL_DATA7,  WBL_DATA6,  WBL_DATA5,
                             WBL_DATA4,  WBL_DATA3,  WBL_DATA2,  WBL_DATA1} : wbl_q;
        busy_d   = (state_d != S_IDLE);
        pre_d    = (state_d == S_PRE);
        wbl_en_d = (state_d == S_SETUP) || (state_d == S_WL);
        wl_en_d  = (state_d == S_WL);
        wl_sel_d = wl_en_d ? row_onehot(addr_d) : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wbl_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pre_q    <= 1'b0;
            wbl_en_q <= 1'b0;
            wl_en_q  <= 1'b0;
            wl_sel_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wbl_q    <= wbl_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pre_q    <= pre_d;
            wbl_en_q <= wbl_en_d;
            wl_en_q  <= wl_en_d;
            wl_sel_q <= wl_sel_d;
        end
    end

`ifdef DRAM_WR_ERR_CHECK_EN
    logic err_q, err_d;
    logic io_en_prev_q, io_en_prev_d;

    // A repeated request in IDLE implies the same request was already accepted or collided.
    always_comb begin
        err_d        = err_q | (IO_EN & (busy_q | io_en_prev_q));
        io_en_prev_d = IO_EN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q        <= 1'b0;
            io_en_prev_q <= 1'b0;
        end else begin
            err_q        <= err_d;
            io_en_prev_q <= io_en_prev_d;
        end
    end

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign wr_done = done_q;
    assign BUSY    = busy_q;
    assign PRE     = pre_q;
    assign WBL_EN  = wbl_en_q;
    assign WBL_OUT = wbl_q;
    assign WL_EN   = wl_en_q;
    assign WL_SEL  = wl_sel_q;

endmodule

// File: tb/tb_dram_wbl_wr_ctrl.sv
// tb/tb_dram_wbl_wr_ctrl.sv - bench for dram_wbl_wr_ctrl, default timing and a 1/3/1/1 instance on shared stimulus
module tb_dram_wbl_wr_ctrl;

`ifdef DRAM_WR_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        io_en;
    logic [5:0]  addr;
    logic [63:0] wd [16];

    logic          done_o [2];
    logic          busy_o [2];
    logic          pre_o [2];
    logic          wblen_o [2];
    logic          wlen_o [2];
    logic          err_o [2];
    logic [1023:0] wout_o [2];
    logic [63:0]   wsel_o [2];

    int tp [2] = '{2, 1};
    int ts [2] = '{1, 3};
    int tw [2] = '{4, 1};
    int tr [2] = '{2, 1};

    bit            act [2];
    int            kk [2];
    logic [5:0]    maddr [2];
    logic [1023:0] mdata [2];
    bit            merr [2];
    bit            prev_io;
    int            cyc;
    int            vectors;
    int            miscompares;

    always #5 clk = ~clk;

    dram_wbl_wr_ctrl u_dut0 (
        .CLK(clk), .RST(rst), .IO_EN(io_en), .ADDR(addr),
        .WBL_DATA1(wd[0]),   .WBL_DATA2(wd[1]),   .WBL_DATA3(wd[2]),   .WBL_DATA4(wd[3]),
        .WBL_DATA5(wd[4]),   .WBL_DATA6(wd[5]),   .WBL_DATA7(wd[6]),   .WBL_DATA8(wd[7]),
        .WBL_DATA9(wd[8]),   .WBL_DATA10(wd[9]),  .WBL_DATA11(wd[10]), .WBL_DATA12(wd[11]),
        .WBL_DATA13(wd[12]), .WBL_DATA14(wd[13]), .WBL_DATA15(wd[14]), .WBL_DATA16(wd[15]),
        .wr_done(done_o[0]), .BUSY(busy_o[0]), .PRE(pre_o[0]), .WBL_EN(wblen_o[0]),
        .WBL_OUT(wout_o[0]), .WL_EN(wlen_o[0]), .WL_SEL(wsel_o[0]), .ERR(err_o[0])
    );

    dram_wbl_wr_ctrl #(
        .T_PRE(1), .T_SETUP(3), .T_WL(1), .T_REC(1)
    ) u_dut1 (
        .CLK(clk), .RST(rst), .IO_EN(io_en), .ADDR(addr),
        .WBL_DATA1(wd[0]),   .WBL_DATA2(wd[1]),   .WBL_DATA3(wd[2]),   .WBL_DATA4(wd[3]),
        .WBL_DATA5(wd[4]),   .WBL_DATA6(wd[5]),   .WBL_DATA7(wd[6]),   .WBL_DATA8(wd[7]),
        .WBL_DATA9(wd[8]),   .WBL_DATA10(wd[9]),  .WBL_DATA11(wd[10]), .WBL_DATA12(wd[11]),
        .WBL_DATA13(wd[12]), .WBL_DATA14(wd[13]), .WBL_DATA15(wd[14]), .WBL_DATA16(wd[15]),
        .wr_done(done_o[1]), .BUSY(busy_o[1]), .PRE(pre_o[1]), .WBL_EN(wblen_o[1]),
        .WBL_OUT(wout_o[1]), .WL_EN(wlen_o[1]), .WL_SEL(wsel_o[1]), .ERR(err_o[1])
    );

    task automatic chk(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s[%0d] got %0h exp %0h at cycle %0d", tag, i, got, exp, cyc);
        end
        vectors++;
    endtask

    // Reference: a write accepted at edge k owns fixed windows counted from k.
    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit busy;
            int tot;
            tot  = tp[i] + ts[i] + tw[i] + tr[i];
            busy = act[i] && ((cyc - kk[i]) <= tot);
            if (rst) begin
                act[i]   = 1'b0;
                maddr[i] = '0;
                mdata[i] = '0;
                merr[i]  = 1'b0;
            end else begin
                if (ERR_EN && io_en && (busy || prev_io)) merr[i] = 1'b1;
                if (io_en && !busy) begin
                    act[i]   = 1'b1;
                    kk[i]    = cyc;
                    maddr[i] = addr;
                    for (int j = 0; j < 16; j++) mdata[i][j*64 +: 64] = wd[j];
                end
            end
        end
        prev_io = rst ? 1'b0 : io_en;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int d, tot;
            bit e_pre, e_wbl, e_wl, e_busy, e_done;
            logic [63:0] e_sel;
            d      = cyc + 1 - kk[i];
            tot    = tp[i] + ts[i] + tw[i] + tr[i];
            e_pre  = act[i] && d >= 1 && d <= tp[i];
            e_wbl  = act[i] && d >= tp[i] + 1 && d <= tp[i] + ts[i] + tw[i];
            e_wl   = act[i] && d >= tp[i] + ts[i] + 1 && d <= tp[i] + ts[i] + tw[i];
            e_busy = act[i] && d >= 1 && d <= tot;
            e_done = act[i] && d == tot + 1;
            e_sel  = e_wl ? (64'd1 << maddr[i]) : 64'd0;
            chk("PRE", i, 64'(pre_o[i]), 64'(e_pre));
            chk("WBL_EN", i, 64'(wblen_o[i]), 64'(e_wbl));
            chk("WL_EN", i, 64'(wlen_o[i]), 64'(e_wl));
            chk("WL_SEL", i, wsel_o[i], e_sel);
            chk("BUSY", i, 64'(busy_o[i]), 64'(e_busy));
            chk("wr_done", i, 64'(done_o[i]), 64'(e_done));
            chk("ERR", i, 64'(err_o[i]), 64'(merr[i]));
            for (int j = 0; j < 16; j++) chk("WBL_OUT", i, wout_o[i][j*64 +: 64], mdata[i][j*64 +: 64]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        check_all();
    endtask

    task automatic wait_done0(output int at);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (done_o[0] !== 1'b1 && n < 20);
        chk("wait_done", 0, 64'(done_o[0]), 64'd1);
        at = cyc;
    endtask

    task automatic rand_data();
        for (int j = 0; j < 16; j++) wd[j] = {$urandom, $urandom};
    endtask

    initial begin
        int last, t, ndone, k0;
        cyc = 0; vectors = 0; miscompares = 0; prev_io = 1'b0;
        for (int i = 0; i < 2; i++) begin
            act[i] = 1'b0; kk[i] = 0; maddr[i] = '0; mdata[i] = '0; merr[i] = 1'b0;
        end
        rst = 1'b1; io_en = 1'b0; addr = '0;
        rand_data();
        repeat (3) tick();
        chk("rst_BUSY", 0, 64'(busy_o[0]), 64'd0);
        chk("rst_WBL_OUT", 0, wout_o[0][63:0], 64'd0);
        rst = 1'b0;
        tick();

        // single write to row 5
        for (int j = 0; j < 16; j++) wd[j] = 64'd0;
        wd[0] = 64'h0123456789ABCDEF; addr = 6'h05; io_en = 1'b1;
        tick();
        io_en = 1'b0;
        for (int j = 2; j <= 10; j++) begin
            tick();
            if (j >= 4 && j <= 7) chk("single_WL_SEL", 0, wsel_o[0], 64'h20);
            chk("single_done", 0, 64'(done_o[0]), 64'(j == 10));
        end
        chk("single_WBL_OUT", 0, wout_o[0][63:0], 64'h0123456789ABCDEF);
        repeat (4) tick();

        // back-to-back over all 64 rows, each request issued in the wr_done cycle
        addr = 6'd0; io_en = 1'b1; rand_data();
        tick();
        io_en = 1'b0;
        wait_done0(last);
        for (int r = 1; r < 64; r++) begin
            addr = 6'(r); io_en = 1'b1; rand_data();
            tick();
            io_en = 1'b0;
            if (r == 63) begin
                repeat (3) tick();
                chk("row63_WL_SEL", 0, wsel_o[0], 64'h8000_0000_0000_0000);
            end
            wait_done0(t);
            chk("b2b_gap", 0, 64'(t - last), 64'd10);
            last = t;
        end
        repeat (12) tick();

        // request collision during an active write
        addr = 6'h02; io_en = 1'b1; rand_data();
        tick();
        io_en = 1'b0;
        repeat (3) tick();
        addr = 6'h10; io_en = 1'b1; rand_data();
        tick();
        io_en = 1'b0;
        ndone = 0;
        repeat (12) begin
            tick();
            if (done_o[0] === 1'b1) ndone++;
        end
        chk("collide_ndone", 0, 64'(ndone), 64'd1);
        chk("collide_ERR", 0, 64'(err_o[0]), 64'(ERR_EN));

        // reset during the wordline phase
        rst = 1'b1; tick(); rst = 1'b0; tick();
        addr = 6'h21; io_en = 1'b1; rand_data();
        tick();
        io_en = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_BUSY", 0, 64'(busy_o[0]), 64'd0);
        chk("rstmid_WL_EN", 0, 64'(wlen_o[0]), 64'd0);
        chk("rstmid_WL_SEL", 0, wsel_o[0], 64'd0);
        chk("rstmid_WBL_OUT", 0, wout_o[0][63:0], 64'd0);
        ndone = 0;
        repeat (12) begin
            tick();
            if (done_o[0] === 1'b1) ndone++;
        end
        chk("rstmid_ndone", 0, 64'(ndone), 64'd0);
        addr = 6'h3F; io_en = 1'b1; rand_data();
        tick();
        k0 = cyc;
        io_en = 1'b0;
        wait_done0(t);
        chk("rstmid_fresh_lat", 0, 64'(t - k0), 64'd9);

        // reset and request together: reset wins
        rst = 1'b1; io_en = 1'b1;
        tick();
        rst = 1'b0; io_en = 1'b0;
        chk("rst_io_BUSY", 0, 64'(busy_o[0]), 64'd0);
        tick();
        chk("rst_io_BUSY2", 0, 64'(busy_o[0]), 64'd0);

        // short-timing instance: WL at k+5, done at k+7
        repeat (12) tick();
        addr = 6'h0A; io_en = 1'b1; rand_data();
        tick();
        io_en = 1'b0;
        for (int j = 2; j <= 10; j++) begin
            tick();
            chk("sweep_WL_EN", 1, 64'(wlen_o[1]), 64'(j == 5));
            chk("sweep_done", 1, 64'(done_o[1]), 64'(j == 7));
        end

        // randomized traffic with occasional resets
        repeat (300) begin
            rst   = ($urandom_range(99) == 0);
            io_en = ($urandom_range(3) == 0);
            addr  = 6'($urandom);
            rand_data();
            tick();
        end
        rst = 1'b0; io_en = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
